// File: rtl/uart_tx_drain_if.sv
// FIFO read-port handshake between the TX byte FIFO and the UART drain.
// The drain takes the master modport because it issues the pop strobe.
interface uart_tx_drain_if;
    logic       i_fifo_empty_n;
    logic [7:0] i_fifo_data;
    logic       o_fifo_rd;

    modport master (
        input  i_fifo_empty_n,
        input  i_fifo_data,
        output o_fifo_rd
    );

    modport slave (
        output i_fifo_empty_n,
        output i_fifo_data,
        input  o_fifo_rd
    );
endinterface

// File: rtl/uart_tx_drain.sv
// 8N1 UART transmitter that pops bytes from a first-word-fall-through FIFO.
// Optional UART_TX_CTS_EN adds an i_cts_n flow-control input behind a 2-flop synchronizer.
module uart_tx_drain #(
    parameter logic [23:0] CLOCKS_PER_BAUD = 24'd868
) (
    input  logic            i_clk,
    input  logic            i_reset,
`ifdef UART_TX_CTS_EN
    input  logic            i_cts_n,
`endif
    uart_tx_drain_if.master fifo,
    output logic            o_uart_tx,
    output logic            o_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [23:0] BAUD_RELOAD = CLOCKS_PER_BAUD - 24'd1;

    state_t      state_q, state_d;
    logic [23:0] baud_q, baud_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        cts_ok;
    logic        bit_end;
    logic        launch;

`ifdef UART_TX_CTS_EN
    logic cts_meta_q, cts_sync_q;

    // Synchronizer resets to "not clear" so nothing launches until CTS is seen low.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cts_meta_q <= 1'b1;
            cts_sync_q <= 1'b1;
        end else begin
            cts_meta_q <= i_cts_n;
            cts_sync_q <= cts_meta_q;
        end
    end

    assign cts_ok = !cts_sync_q;
`else
    assign cts_ok = 1'b1;
`endif

    assign bit_end = (baud_q == 24'd0);

    // Launch from IDLE, or on the last STOP cycle for gapless back-to-back frames.
    assign launch = fifo.i_fifo_empty_n && cts_ok && !i_reset &&
                    ((state_q == IDLE) || ((state_q == STOP) && bit_end));

    assign fifo.o_fifo_rd = launch;

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;

        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d   = START;
                    baud_d    = BAUD_RELOAD;
                    shift_d   = fifo.i_fifo_data;
                    bit_idx_d = 3'd0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    baud_d    = BAUD_RELOAD;
                    bit_idx_d = 3'd0;
                end else begin
                    baud_d = baud_q - 24'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d    = BAUD_RELOAD;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    baud_d = baud_q - 24'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (launch) begin
                        state_d   = START;
                        baud_d    = BAUD_RELOAD;
                        shift_d   = fifo.i_fifo_data;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - 24'd1;
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = 24'd0;
            end
        endcase

        // Line level is derived from the next state so the pad is driven straight from a flop.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            baud_q    <= 24'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    assign o_uart_tx = tx_q;
    assign o_busy    = (state_q != IDLE);

endmodule

// File: doc/uart_tx_drain.md
# uart_tx_drain

Serial UART transmitter that drains the TX byte FIFO: pops bytes from the FIFO read port and shifts them out as 8N1 frames, LSB first. Sits between the TX instance of the UART FIFO (RXFIFO=0) and the `o_uart_tx` pad. It is the consumer end of the FIFO's read handshake.

## Interface
Parameters:
- CLOCKS_PER_BAUD, 24'd868, i_clk cycles per bit; legal range 2..2^24-1.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_fifo_empty_n  in  1  FIFO holds at least one byte; i_fifo_data valid when high.
- i_fifo_data  in  8  head-of-FIFO byte, first-word-fall-through.
- o_fifo_rd  out  1  one-cycle pop strobe; combinational.
- i_cts_n  in  1  clear-to-send, active low; present only with UART_TX_CTS_EN.
- o_uart_tx  out  1  serial line; idle high.
- o_busy  out  1  high while a frame is in progress.

## Operation
- States: IDLE, START, DATA, STOP.
- Launch condition L = i_fifo_empty_n && cts_ok && !i_reset && (state==IDLE || (state==STOP && baud_cnt==0)).
- o_fifo_rd = L. On the same edge, the block captures i_fifo_data into an 8-bit shift register and enters START with baud_cnt = CLOCKS_PER_BAUD-1.
- The FIFO pops on that edge. The next head byte becomes valid one cycle later, well before the next launch.
- Baud counter: 24-bit down counter. A bit period ends at the cycle where baud_cnt==0; the counter then reloads CLOCKS_PER_BAUD-1.
- START: o_uart_tx=0 for one bit period, then go to DATA with bit_idx=0.
- DATA: o_uart_tx = shift_reg[0]. At the end of each bit period: shift right and increment the 3-bit bit_idx. After bit_idx==7 completes, go to STOP.
- STOP: o_uart_tx=1 for one bit period. At the end of the period:
  - if L holds, go to START (back-to-back frame, no idle gap);
  - otherwise go to IDLE.
- o_uart_tx is registered and is a pure function of state and shift_reg[0]. It is 1 in IDLE.
- o_busy = (state != IDLE). It stays high across back-to-back frames.
- The FIFO empty with no frame in flight: o_fifo_rd never asserts, and the line holds 1.
- i_fifo_empty_n rising during mid-frame has no effect until the last STOP cycle.

## Timing
- Reset values: state=IDLE, o_uart_tx=1, o_busy=0, o_fifo_rd=0, baud_cnt=0, bit_idx=0, shift_reg=0.
- Latency: launch at edge N; start bit begins at cycle N+1 (o_uart_tx low at N+1).
- Frame length is exactly 10*CLOCKS_PER_BAUD cycles.
- Back-to-back frame period is exactly 10*CLOCKS_PER_BAUD cycles.
- From IDLE, the launch occurs in the first cycle where i_fifo_empty_n=1, with at most one cycle of pad to the start bit.
- Reset mid-frame: o_uart_tx=1 and state=IDLE on the following cycle. The in-flight byte is lost and the truncated frame is not resent. o_fifo_rd is 0 during the reset cycle.
- At most one o_fifo_rd pulse per frame. o_fifo_rd is never asserted while i_fifo_empty_n=0, so no FIFO underflow.

## Configuration
- UART_TX_CTS_EN defined:
  - i_cts_n port exists and passes through a 2-flop synchronizer (reset to 1 = not clear); cts_ok = !cts_sync.
  - Deasserting i_cts_n blocks new launches only. A frame already started completes.
  - Latency from i_cts_n falling to launch is 2-3 cycles.
- UART_TX_CTS_EN undefined: the port and synchronizer are absent and cts_ok=1.

## Test plan
- CLOCKS_PER_BAUD=4, FIFO holds 0xA3:
  - one o_fifo_rd pulse;
  - line sequence, 4 cycles each: 0 | 1,1,0,0,0,1,0,1 | 1;
  - o_busy high for 40 cycles, then IDLE.
- CLOCKS_PER_BAUD=4, bytes 0x55, 0x0F queued: second o_fifo_rd in the last STOP cycle of frame 1; second start bit immediately follows; total 80 busy cycles, no high gap longer than one stop bit.
- Empty FIFO for 1000 cycles: o_fifo_rd=0, o_uart_tx=1, o_busy=0.
- Reset asserted in DATA bit 3 of 0xFF: next cycle o_uart_tx=1, o_busy=0, and no pop occurs during reset. A byte queued afterwards starts a clean frame.
- UART_TX_CTS_EN, i_cts_n=1 with 0x41 queued: no pop. Drop i_cts_n: pop within 3 cycles. Raise i_cts_n mid-frame: the frame completes and the next queued byte is held.
- CLOCKS_PER_BAUD=2 (minimum), 3 back-to-back bytes: each frame is 20 cycles and every byte is read exactly once.
